// File: rtl/bit_serial_adder.sv
// Bit-serial adder: latches two WIDTH-bit operands and a carry-in, then adds
// them LSB-first with one full-adder slice per cycle, holding the carry in a flop.
// Optional feature macro: OVERFLOW_FLAG_EN adds a signed-overflow output.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow_out
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    count;

  logic             ha1_s_c;
  logic             ha1_c_c;
  logic             ha2_c_c;
  logic             sum_bit_c;
  logic             carry_next_c;

  // Full-adder slice built from two half adders and an OR
  always_comb begin
    ha1_s_c      = a_sr[0] ^ b_sr[0];
    ha1_c_c      = a_sr[0] & b_sr[0];
    sum_bit_c    = ha1_s_c ^ carry;
    ha2_c_c      = ha1_s_c & carry;
    carry_next_c = ha1_c_c | ha2_c_c;
  end

  // Status flags decode straight from the registered state
  assign busy_out = (state == RUN);
  assign done_out = (state == DONE);

  // Control FSM and serial datapath: load on an accepted start, one bit per RUN cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      carry        <= 1'b0;
      count        <= '0;
      sum_out      <= '0;
      carry_out    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      overflow_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            state        <= RUN;
            a_sr         <= a_in;
            b_sr         <= b_in;
            carry        <= cin_in;
            count        <= '0;
            sum_out      <= '0;
            carry_out    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            overflow_out <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // start_in is deliberately ignored here; the add in flight runs to completion
          sum_out <= {sum_bit_c, sum_out[WIDTH-1:1]};
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          carry   <= carry_next_c;
          count   <= count + CW'(1);
          if (count == LAST_BIT) begin
            state        <= DONE;
            carry_out    <= carry_next_c;
`ifdef OVERFLOW_FLAG_EN
            // Carry into the MSB differs from carry out of it: signed overflow
            overflow_out <= carry ^ carry_next_c;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
